muldiv_unit: RTL

- Iterative signed 32-bit multiply/divide responder for the multicycle control FSM.
- The control FSM pulses `start` from its execute state, then waits on `done`. Results land in the architectural HI/LO registers.
- Divide-by-zero is reported with the completion pulse, so the control FSM can branch to its exception sequence.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_sign_fix.sv | 15 +
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default operand width, op encodings, FSM state codes.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic OP_DIV  = 1'b0;
   localparam logic OP_MULT = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_PREP = 3'd1;
   localparam state_t ST_ITER = 3'd2;
   localparam state_t ST_FIX  = 3'd3;
   localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/completion bundle between control FSM and muldiv_unit.
// Latency: n/a (wires only).
// Backpressure: none; requests arriving while busy are dropped by the unit.
// master (control FSM): drives start/op/a/b, observes busy/done/div_zero/hi/lo.
// slave  (muldiv_unit): the reverse.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate (abs when negate = sign bit).
// Latency: combinational.
// Backpressure: none.
// Ports: in_dat (W), negate (1) -> out_dat (W).
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] in_dat,
   input  logic         negate,
   output logic [W-1:0] out_dat
);

   assign out_dat = negate ? (W'(0) - in_dat) : in_dat;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed WIDTH-bit divide (restoring) and optional multiply (shift-add).
// Latency: done on edge WIDTH+3 after the start edge; divide-by-zero / disabled mult on edge 3.
// Backpressure: start is accepted only in IDLE or DONE; pulses while busy are dropped.
// Ports: clk, reset (sync, active-high); bus (muldiv_unit_if.slave): start/op/a/b in,
//        busy/done/div_zero/hi/lo out.
// Build option: define MULT_EN to compile in the multiplier; otherwise op=1 is a no-op.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             op_q;
   logic             neg_q;      // result sign: sign(a) xor sign(b)
   logic             sa_q;       // remainder takes the dividend's sign
   logic             skip_q;     // short path: leave hi/lo untouched in FIX
   logic             dz_q;
   logic [WIDTH-1:0] quo, rem, dvs;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
   logic [WIDTH:0]   part_rem;
   logic             can_sub;
   logic             prep_dz, prep_skip;

   muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.in_dat(a_q), .negate(a_q[WIDTH-1]), .out_dat(mag_a));
   muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.in_dat(b_q), .negate(b_q[WIDTH-1]), .out_dat(mag_b));
   muldiv_sign_fix #(.W(WIDTH)) u_fix_q (.in_dat(quo), .negate(neg_q),        .out_dat(q_fix));
   muldiv_sign_fix #(.W(WIDTH)) u_fix_r (.in_dat(rem), .negate(sa_q),         .out_dat(r_fix));

   // Restoring step: shift the next dividend bit into the WIDTH+1-bit partial remainder.
   assign part_rem = {rem, quo[WIDTH-1]};
   assign can_sub  = (part_rem >= {1'b0, dvs});

   assign prep_dz = (op_q == OP_DIV) && (b_q == '0);
`ifdef MULT_EN
   assign prep_skip = prep_dz;

   // Multiplier magnitude sits in acc's low half; multiplicand is dvs (|b|).
   logic [2*WIDTH-1:0] acc, p_fix;
   logic [WIDTH:0]     msum;

   assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});

   muldiv_sign_fix #(.W(2*WIDTH)) u_fix_p (.in_dat(acc), .negate(neg_q), .out_dat(p_fix));
`else
   assign prep_skip = prep_dz || (op_q == OP_MULT);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_DIV;
         neg_q  <= 1'b0;
         sa_q   <= 1'b0;
         skip_q <= 1'b0;
         dz_q   <= 1'b0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
`ifdef MULT_EN
         acc    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  a_q   <= bus.a;
                  b_q   <= bus.b;
                  op_q  <= bus.op;
                  state <= ST_PREP;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_PREP: begin
               neg_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
               sa_q   <= a_q[WIDTH-1];
               quo    <= mag_a;
               dvs    <= mag_b;
               rem    <= '0;
               cnt    <= '0;
               dz_q   <= prep_dz;
               skip_q <= prep_skip;
`ifdef MULT_EN
               acc    <= {{WIDTH{1'b0}}, mag_a};
`endif
               // Short paths still pass through FIX so done lands on edge 3.
               state  <= prep_skip ? ST_FIX : ST_ITER;
            end
            ST_ITER: begin
               // Both datapaths step every cycle; FIX picks the one op_q asked for.
               rem <= can_sub ? WIDTH'(part_rem - {1'b0, dvs}) : part_rem[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], can_sub};
`ifdef MULT_EN
               acc <= {msum, acc[WIDTH-1:1]};
`endif
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
            end
            ST_FIX: begin
               if (!skip_q) begin
`ifdef MULT_EN
                  if (op_q == OP_MULT) begin
                     hi_q <= p_fix[2*WIDTH-1:WIDTH];
                     lo_q <= p_fix[WIDTH-1:0];
                  end else begin
                     hi_q <= r_fix;
                     lo_q <= q_fix;
                  end
`else
                  hi_q <= r_fix;
                  lo_q <= q_fix;
`endif
               end
               state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
   assign bus.done     = (state == ST_DONE);
   assign bus.div_zero = (state == ST_DONE) && dz_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule
